// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared types and constants for the pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_BITS_DEFAULT = 5;

    typedef struct packed {
        logic Clock;
        logic Reset;
    } Data_Control_T;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } muldiv_state_t;

    // Winning stall/flush cause, in priority order; also a debug trace point.
    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_EXT      = 3'd1,
        CAUSE_BRANCH   = 3'd2,
        CAUSE_LOAD_USE = 3'd3,
        CAUSE_HILO     = 3'd4
    } hazard_cause_t;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_muldiv_timer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_muldiv_timer
// Brief    : Mult/div occupancy timer; raises busy for MULDIV_CYCLES-1 cycles
//            after a start and flags a sticky error on a start while busy.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_muldiv_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy,
    output logic o_err
);

    localparam int unsigned          c_CNT_W = cnt_width(MULDIV_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_LOAD  = c_CNT_W'(MULDIV_CYCLES - 2);
    localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

    muldiv_state_t        r_state;
    muldiv_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_err;
    logic                 w_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The count runs free of ext_stall: the unit keeps computing while the pipe is frozen.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            ST_RUN: begin
                if (i_start) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = c_LOAD;
                end
            end
            ST_BUSY: begin
                if (i_start) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == ST_BUSY);
    assign o_err  = r_err;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Central stall/flush sequencer driving the IF/ID and ID/EX stage
//            enables and bubble strobes, with a stall performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_BITS      = REG_BITS_DEFAULT,
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_BITS      = 16
) (
    input  Data_Control_T        ctrl,
    input  logic [REG_BITS-1:0]  id_rs,
    input  logic                 id_rs_used,
    input  logic [REG_BITS-1:0]  id_rt,
    input  logic                 id_rt_used,
    input  logic                 id_hilo,
    input  logic                 ex_load,
    input  logic [REG_BITS-1:0]  ex_rd,
    input  logic                 ex_branch_taken,
    input  logic                 ex_muldiv_start,
    input  logic                 ext_stall,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 muldiv_busy,
    output logic                 err,
    output logic [CNT_BITS-1:0]  stall_count
);

    logic                 clk;
    logic                 rst_n;
    logic                 w_busy;
    logic                 w_err;
    logic                 w_load_use;
    logic                 w_hilo_haz;
    hazard_cause_t        w_cause;
    logic                 w_pc_en;
    logic                 w_ifid_en;
    logic                 w_idex_en;
    logic                 w_ifid_flush;
    logic                 w_idex_flush;
    logic [CNT_BITS-1:0]  r_stall_count;

    assign clk   = ctrl.Clock;
    assign rst_n = ctrl.Reset;

    pipeline_hazard_ctrl_muldiv_timer #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (ex_muldiv_start),
        .o_busy  (w_busy),
        .o_err   (w_err)
    );

    // r0 is hard-wired zero, so a load targeting it can never create a dependency.
    assign w_load_use = ex_load && (ex_rd != '0) &&
                        ((id_rs_used && (id_rs == ex_rd)) ||
                         (id_rt_used && (id_rt == ex_rd)));

    assign w_hilo_haz = id_hilo && (w_busy || ex_muldiv_start);

    always_comb begin
        w_cause = CAUSE_NONE;
        if (ext_stall) begin
            w_cause = CAUSE_EXT;
        end else if (ex_branch_taken) begin
            w_cause = CAUSE_BRANCH;
        end else if (w_load_use) begin
            w_cause = CAUSE_LOAD_USE;
        end else if (w_hilo_haz) begin
            w_cause = CAUSE_HILO;
        end
    end

    // While reset is held the pipe registers are frozen and forced to bubbles.
    always_comb begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_idex_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (!rst_n) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            case (w_cause)
                CAUSE_EXT: begin
                    w_pc_en   = 1'b0;
                    w_ifid_en = 1'b0;
                    w_idex_en = 1'b0;
                end
                CAUSE_BRANCH: begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end
                CAUSE_LOAD_USE, CAUSE_HILO: begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!w_pc_en && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_BITS'(1);
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign idex_en     = w_idex_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign muldiv_busy = w_busy;
    assign err         = w_err;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed plus randomized bench for pipeline_hazard_ctrl against a
//            cycle-level reference model of the stall/flush rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int unsigned REG_BITS      = 5;
    localparam int unsigned MULDIV_CYCLES = 4;
    localparam int unsigned CNT_BITS      = 5;
    localparam int          STALL_SAT     = (1 << CNT_BITS) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    Data_Control_T ctrl;

    logic [REG_BITS-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_rs_used = 0, id_rt_used = 0, id_hilo = 0, ex_load = 0;
    logic ex_branch_taken = 0, ex_muldiv_start = 0, ext_stall = 0;
    logic pc_en, ifid_en, idex_en, ifid_flush, idex_flush, muldiv_busy, err;
    logic [CNT_BITS-1:0] stall_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: cycles of busy remaining, sticky error, stall total.
    int m_busy_left = 0;
    bit m_err = 0;
    int m_stall = 0;

    assign ctrl = '{Clock: clk, Reset: rst_n};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_BITS      (REG_BITS),
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_BITS      (CNT_BITS)
    ) dut (
        .ctrl            (ctrl),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .id_rt           (id_rt),
        .id_rt_used      (id_rt_used),
        .id_hilo         (id_hilo),
        .ex_load         (ex_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .ext_stall       (ext_stall),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .muldiv_busy     (muldiv_busy),
        .err             (err),
        .stall_count     (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {pc_en, ifid_en, idex_en, ifid_flush, idex_flush}.
    function automatic logic [4:0] exp_ctrl();
        bit lu, hh;
        lu = ex_load && (ex_rd != 0) &&
             ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
        hh = id_hilo && ((m_busy_left > 0) || ex_muldiv_start);
        if (!rst_n)          return 5'b00011;
        if (ext_stall)       return 5'b00000;
        if (ex_branch_taken) return 5'b11111;
        if (lu || hh)        return 5'b00101;
        return 5'b11100;
    endfunction

    task automatic model_reset();
        m_busy_left = 0;
        m_err       = 0;
        m_stall     = 0;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_rs_used = 0; id_rt_used = 0; id_hilo = 0; ex_load = 0;
        ex_branch_taken = 0; ex_muldiv_start = 0; ext_stall = 0;
    endtask

    task automatic step(input string tag);
        logic [4:0] e;
        @(negedge clk);
        e = exp_ctrl();
        chk({tag, "/ctl"}, {27'd0, pc_en, ifid_en, idex_en, ifid_flush, idex_flush}, {27'd0, e});
        chk({tag, "/busy"}, {31'd0, muldiv_busy}, {31'd0, (m_busy_left > 0)});
        chk({tag, "/err"}, {31'd0, err}, {31'd0, m_err});
        chk({tag, "/stall_cnt"}, 32'(stall_count), 32'(m_stall));
        @(posedge clk);
        if (rst_n) begin
            if (!e[4] && m_stall < STALL_SAT) m_stall++;
            if (m_busy_left > 0) begin
                if (ex_muldiv_start) m_err = 1;
                m_busy_left--;
            end else if (ex_muldiv_start) begin
                m_busy_left = MULDIV_CYCLES - 1;
            end
        end
        #1;
    endtask

    initial begin
        // Reset held
        step("rst0");
        step("rst1");
        rst_n = 1'b1;
        step("idle");

        // Load-use on rs
        ex_load = 1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1;
        step("load_use");
        chk("load_use_count", 32'(stall_count), 32'd1);
        clear_inputs();
        step("after_lu");

        // Load to r0 never stalls
        ex_load = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rs_used = 1;
        step("zero_reg");
        ex_rd = 5'd3; id_rs = 5'd1; id_rt = 5'd3; id_rt_used = 1;
        step("load_use_rt");
        clear_inputs();

        // Branch masks a simultaneous load-use
        ex_load = 1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1; ex_branch_taken = 1;
        step("br_over_haz");
        clear_inputs();

        // Branch held under a 3-cycle freeze, flushes when the freeze drops
        ex_branch_taken = 1; ext_stall = 1;
        step("br_frz0");
        step("br_frz1");
        step("br_frz2");
        ext_stall = 0;
        step("br_frz_release");
        clear_inputs();
        step("idle2");

        // Mult/div occupancy with dependent HI/LO reader
        ex_muldiv_start = 1;
        step("md_start");
        chk("md_busy_after_start", {31'd0, muldiv_busy}, 32'd1);
        ex_muldiv_start = 0; id_hilo = 1;
        step("md_b1");
        step("md_b2");
        step("md_b3");
        chk("md_busy_done", {31'd0, muldiv_busy}, 32'd0);
        chk("md_pc_resume", {31'd0, pc_en}, 32'd1);
        step("md_free");
        clear_inputs();

        // Second start while busy -> sticky error, timing unchanged
        ex_muldiv_start = 1;
        step("pe_start");
        ex_muldiv_start = 0;
        step("pe_b1");
        ex_muldiv_start = 1;
        step("pe_b2");
        chk("pe_err_set", {31'd0, err}, 32'd1);
        ex_muldiv_start = 0;
        step("pe_b3");
        chk("pe_busy_end", {31'd0, muldiv_busy}, 32'd0);
        step("pe_after");

        // Asynchronous reset mid-BUSY
        ex_muldiv_start = 1;
        step("rs_start");
        ex_muldiv_start = 0; id_hilo = 1;
        step("rs_b1");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rs_async_busy", {31'd0, muldiv_busy}, 32'd0);
        chk("rs_async_err", {31'd0, err}, 32'd0);
        chk("rs_async_cnt", 32'(stall_count), 32'd0);
        chk("rs_async_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);
        step("rs_held");
        rst_n = 1'b1;
        clear_inputs();
        step("rs_released");

        // Randomized traffic, including occasional resets and counter saturation
        for (int i = 0; i < 400; i++) begin
            ext_stall       = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_load         = ($urandom_range(0, 2) == 0);
            ex_rd           = REG_BITS'($urandom_range(0, 3));
            id_rs           = REG_BITS'($urandom_range(0, 3));
            id_rt           = REG_BITS'($urandom_range(0, 3));
            id_rs_used      = $urandom_range(0, 1) == 1;
            id_rt_used      = $urandom_range(0, 1) == 1;
            id_hilo         = ($urandom_range(0, 3) == 0);
            ex_muldiv_start = ($urandom_range(0, 11) == 0);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline register chain (IF/ID, ID/EX and the delay-line stages after them).
- Detects load-use and HI/LO hazards, squashes wrong-path instructions on taken branches, and tracks the multi-cycle mult/div unit.
- Emits per-stage enable and flush strobes that drive the pipeline registers.
- Sits beside the ID/EX boundary and is the only source of stage enables.

Parameters:
- REG_BITS, 5: register index width.
- MULDIV_CYCLES, 32: mult/div occupancy in cycles, including the start cycle; must be at least 2.
- CNT_BITS, 16: width of the stall performance counter.

Ports:
- ctrl, input, Data_Control_T bundle: Clock field is the single clock, rising-edge; Reset field is asynchronous and active-low.
- id_rs, input, REG_BITS: rs index of the instruction in ID.
- id_rs_used, input, 1: ID instruction reads rs.
- id_rt, input, REG_BITS: rt index of the instruction in ID.
- id_rt_used, input, 1: ID instruction reads rt.
- id_hilo, input, 1: ID instruction is mfhi/mflo/mthi/mtlo or mult/div.
- ex_load, input, 1: EX instruction is a load.
- ex_rd, input, REG_BITS: destination register of the EX instruction.
- ex_branch_taken, input, 1: branch or jump resolved taken in EX.
- ex_muldiv_start, input, 1: mult/div issues from EX this cycle.
- ext_stall, input, 1: memory wait; freezes the whole pipe.
- pc_en, output, 1: PC load enable.
- ifid_en, output, 1: IF/ID register enable.
- idex_en, output, 1: ID/EX register enable.
- ifid_flush, output, 1: clear IF/ID to a bubble.
- idex_flush, output, 1: clear ID/EX to a bubble.
- muldiv_busy, output, 1: mult/div unit occupied.
- err, output, 1: sticky protocol error.
- stall_count, output, CNT_BITS: cycles with pc_en=0.

Behaviour:
- State machine: RUN and BUSY. Cycle counter cnt is CNT-wide enough to hold MULDIV_CYCLES-1.
- RUN with ex_muldiv_start=1:
  - Next state is BUSY.
  - cnt loads MULDIV_CYCLES-2.
  - muldiv_busy=1 from the next cycle.
- BUSY:
  - cnt decrements every cycle, regardless of ext_stall.
  - When cnt=0, the next state is RUN and muldiv_busy drops.
  - Total muldiv_busy-high cycles equal MULDIV_CYCLES-1.
- ex_muldiv_start=1 while BUSY:
  - err is set and stays set until reset.
  - cnt is not reloaded.
- Hazard conditions, combinational:
  - load_use = ex_load & (ex_rd!=0) & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
  - hilo_haz = id_hilo & (muldiv_busy | ex_muldiv_start).
- Outputs are combinational from state and current inputs; zero-cycle latency. Priority is highest first:
  1. ext_stall: pc_en, ifid_en and idex_en are 0; both flushes are 0. A taken branch is held in EX and flushes once ext_stall drops.
  2. ex_branch_taken: pc_en, ifid_en and idex_en are 1; ifid_flush and idex_flush are 1. This masks a simultaneous hazard.
  3. load_use or hilo_haz: pc_en and ifid_en are 0; idex_en is 1; idex_flush is 1, inserting one bubble per cycle.
  4. Otherwise: all enables are 1; both flushes are 0.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM and forwarding covers it.
- hilo_haz persists until muldiv_busy falls. The ID instruction proceeds in the first cycle with muldiv_busy=0.
- stall_count increments each cycle pc_en=0 and saturates at all-ones.
- Reset asserted, at any time including mid-BUSY:
  - State is RUN, cnt=0, muldiv_busy=0, err=0, stall_count=0.
  - While reset is held, pc_en, ifid_en and idex_en are 0 and ifid_flush and idex_flush are 1.
  - After reset releases, the first rising edge behaves as RUN.

Decomposition:
- Shared package holds:
  - the state enum (RUN, BUSY);
  - the REG_BITS default;
  - a hazard-cause enum (NONE, EXT, BRANCH, LOAD_USE, HILO), used internally and exposed for debug tracing.
- One sub-module, muldiv_timer: the load/decrement counter producing muldiv_busy and err. The priority encoder stays in the top level.

Test Plan:
- Load-use: ex_load=1, ex_rd=8, id_rs=8, id_rs_used=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle; stall_count=1.
- Zero register: same stimulus with ex_rd=0 and id_rs=0 -> no stall; all enables are 1.
- Branch over hazard: ex_branch_taken=1 together with load_use -> ifid_flush=1, idex_flush=1, pc_en=1.
- Branch under freeze: ext_stall=1 and ex_branch_taken=1 for 3 cycles, then ext_stall=0 -> no flush during the 3 cycles; flush on the 4th cycle.
- Mult/div with MULDIV_CYCLES=4: start pulse at cycle 10, id_hilo=1 from cycle 11 -> muldiv_busy high in cycles 11-13; pc_en=0 in cycles 11-13; pc_en=1 in cycle 14.
- Protocol error and reset: second ex_muldiv_start in cycle 12 -> err=1 from cycle 13, busy still ends after cycle 13. Reset low in cycle 12 instead -> muldiv_busy, err and stall_count read 0 immediately; flushes=1 while reset is held.
